scale_xp_sched: RTL and testbench



---
 rtl/scale_xp_pkg.sv | 26 ++
 rtl/scale_xp_opreg.sv | 90 +++++++++
 rtl/scale_xp_sched.sv | 148 ++++++++++++++
 tb/tb_scale_xp_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_xp_pkg.sv
// Shared types and width helpers for the scaled outer-product
// operand scheduler.
package scale_xp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int MAT_SIZE_DEF  = 16;
  localparam int FP_MANT_W_DEF = 23;
  localparam int FP_EXP_W_DEF  = 8;
  localparam int MANT_VEC_W    = FP_MANT_W_DEF * MAT_SIZE_DEF;
  localparam int EXP_VEC_W     = FP_EXP_W_DEF * MAT_SIZE_DEF;

  function automatic int mant_vec_w(input int mant_w, input int n);
    return mant_w * n;
  endfunction

  function automatic int exp_vec_w(input int exp_w, input int n);
    return exp_w * n;
  endfunction

endpackage

// File: rtl/scale_xp_opreg.sv
// Output holding register for the cross-product operand bus:
// valid/ready hold, first/last tags, and a flush that drops a pending beat.
module scale_xp_opreg
  import scale_xp_pkg::*;
#(
  parameter int MVW = MANT_VEC_W,
  parameter int EVW = EXP_VEC_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           flush_i,
  input  logic           ready_i,
  input  logic           first_i,
  input  logic           last_i,
  input  logic [MVW-1:0] a_mant_i,
  input  logic [EVW-1:0] a_exp_i,
  input  logic [MVW-1:0] b_mant_i,
  input  logic [EVW-1:0] b_exp_i,
  output logic           valid_o,
  output logic           first_o,
  output logic           last_o,
  output logic [MVW-1:0] vec1_mant_o,
  output logic [EVW-1:0] vec1_exp_o,
  output logic [MVW-1:0] vec2_mant_o,
  output logic [EVW-1:0] vec2_exp_o
);

  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic [MVW-1:0] m1_q, m1_d, m2_q, m2_d;
  logic [EVW-1:0] e1_q, e1_d, e2_q, e2_d;

  always_comb begin
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    if (flush_i) begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      first_d = first_i;
      last_d  = last_i;
      m1_d    = a_mant_i;
      e1_d    = a_exp_i;
      m2_d    = b_mant_i;
      e2_d    = b_exp_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      m1_q    <= '0;
      m2_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
    end
  end

  assign valid_o     = valid_q;
  assign first_o     = first_q;
  assign last_o      = last_q;
  assign vec1_mant_o = m1_q;
  assign vec1_exp_o  = e1_q;
  assign vec2_mant_o = m2_q;
  assign vec2_exp_o  = e2_q;

endmodule

// File: rtl/scale_xp_sched.sv
// Tile sequencer: joins A/B scale-vector streams into K outer-product
// beats for the cross-product accumulator, with start/done/abort control.
module scale_xp_sched
  import scale_xp_pkg::*;
#(
  parameter int MAT_SIZE  = 16,
  parameter int FP_MANT_W = 23,
  parameter int FP_EXP_W  = 8,
  parameter int K_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [K_W-1:0]                cfg_k_len,
  input  logic                          cfg_abort,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [FP_MANT_W*MAT_SIZE-1:0] a_mant,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]  a_exp,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [FP_MANT_W*MAT_SIZE-1:0] b_mant,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]  b_exp,
  output logic [FP_MANT_W*MAT_SIZE-1:0] xp_vec1_mant,
  output logic [FP_MANT_W*MAT_SIZE-1:0] xp_vec2_mant,
  output logic [FP_EXP_W*MAT_SIZE-1:0]  xp_vec1_exp_raw,
  output logic [FP_EXP_W*MAT_SIZE-1:0]  xp_vec2_exp_raw,
  output logic                          xp_valid,
  output logic                          xp_first,
  output logic                          xp_last,
  input  logic                          xp_ready
);

  localparam int MVW = mant_vec_w(FP_MANT_W, MAT_SIZE);
  localparam int EVW = exp_vec_w(FP_EXP_W, MAT_SIZE);

  state_e         state_q;
  logic [K_W-1:0] k_len_q;
  logic [K_W-1:0] issued_q;
  logic           busy_q;
  logic           done_q;
  logic           aborted_q;

  logic           active;
  logic           kill;
  logic           fire;
  logic           last_step;
  logic [K_W-1:0] k_last;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign kill      = cfg_abort && active;
  assign k_last    = k_len_q - K_W'(1);
  assign last_step = (issued_q == k_last);

  // Abort wins over a same-cycle join so nothing new enters the bus.
  assign fire = (state_q == RUN) && a_valid && b_valid &&
                (!xp_valid || xp_ready) && !cfg_abort;

  assign a_ready = fire;
  assign b_ready = fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_len_q   <= '0;
      issued_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            k_len_q  <= cfg_k_len;
            issued_q <= '0;
            if (cfg_k_len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_abort) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fire) begin
            // Hold issued at k_len-1 so a full-range k_len never wraps.
            if (last_step) state_q <= DRAIN;
            else issued_q <= issued_q + K_W'(1);
          end
        end
        DRAIN: begin
          if (cfg_abort) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (!xp_valid || xp_ready) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

  scale_xp_opreg #(
    .MVW (MVW),
    .EVW (EVW)
  ) u_opreg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (fire),
    .flush_i     (kill),
    .ready_i     (xp_ready),
    .first_i     (issued_q == '0),
    .last_i      (last_step),
    .a_mant_i    (a_mant),
    .a_exp_i     (a_exp),
    .b_mant_i    (b_mant),
    .b_exp_i     (b_exp),
    .valid_o     (xp_valid),
    .first_o     (xp_first),
    .last_o      (xp_last),
    .vec1_mant_o (xp_vec1_mant),
    .vec1_exp_o  (xp_vec1_exp_raw),
    .vec2_mant_o (xp_vec2_mant),
    .vec2_exp_o  (xp_vec2_exp_raw)
  );

endmodule

// File: tb/tb_scale_xp_sched.sv
// Scoreboard bench for scale_xp_sched: input handshakes push expected
// beats, accepted output beats pop and compare.
module tb_scale_xp_sched;

  localparam int MS  = 16;
  localparam int MW  = 23;
  localparam int EW  = 8;
  localparam int KW  = 16;
  localparam int MVW = MW * MS;
  localparam int EVW = EW * MS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_start = 1'b0;
  logic [KW-1:0]  cfg_k_len = '0;
  logic           cfg_abort = 1'b0;
  logic           busy, done, aborted;
  logic           a_valid = 1'b0, b_valid = 1'b0;
  logic           a_ready, b_ready;
  logic [MVW-1:0] a_mant = '0, b_mant = '0;
  logic [EVW-1:0] a_exp = '0, b_exp = '0;
  logic [MVW-1:0] xp_vec1_mant, xp_vec2_mant;
  logic [EVW-1:0] xp_vec1_exp_raw, xp_vec2_exp_raw;
  logic           xp_valid, xp_first, xp_last;
  logic           xp_ready = 1'b1;

  scale_xp_sched #(
    .MAT_SIZE (MS),
    .FP_MANT_W(MW),
    .FP_EXP_W (EW),
    .K_W      (KW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_k_len      (cfg_k_len),
    .cfg_abort      (cfg_abort),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_mant         (a_mant),
    .a_exp          (a_exp),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_mant         (b_mant),
    .b_exp          (b_exp),
    .xp_vec1_mant   (xp_vec1_mant),
    .xp_vec2_mant   (xp_vec2_mant),
    .xp_vec1_exp_raw(xp_vec1_exp_raw),
    .xp_vec2_exp_raw(xp_vec2_exp_raw),
    .xp_valid       (xp_valid),
    .xp_first       (xp_first),
    .xp_last        (xp_last),
    .xp_ready       (xp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MVW-1:0] am;
    logic [EVW-1:0] ae;
    logic [MVW-1:0] bm;
    logic [EVW-1:0] be;
    logic           f;
    logic           l;
  } beat_t;

  beat_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int klen_m = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  int done_n = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int last_hs = 0;
  bit ab_at_done = 1'b0;
  bit prev_fire = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      q.delete();
      prev_fire = 1'b0;
    end else begin
      if (prev_fire) chk("lat1", xp_valid, 1);
      if (xp_valid) begin
        chk("q_has_beat", q.size() == 0, 0);
        if (q.size() != 0) begin
          e = q[0];
          chk("first", xp_first, e.f);
          chk("last", xp_last, e.l);
          chk("v1_mant", xp_vec1_mant, e.am);
          chk("v1_exp", xp_vec1_exp_raw, e.ae);
          chk("v2_mant", xp_vec2_mant, e.bm);
          chk("v2_exp", xp_vec2_exp_raw, e.be);
          if (xp_ready) begin
            void'(q.pop_front());
            out_cnt++;
          end
        end
        if (!xp_ready) chk("stall_ready", {a_ready, b_ready}, 2'b00);
      end
      if (cfg_start && !busy && !done) begin
        klen_m    = int'(cfg_k_len);
        in_cnt    = 0;
        out_cnt   = 0;
        done_n    = 0;
        start_cyc = cyc;
        q.delete();
      end
      if (a_ready || b_ready) begin
        chk("join", {a_valid, b_valid, a_ready, b_ready}, 4'hf);
        e.am = a_mant;
        e.ae = a_exp;
        e.bm = b_mant;
        e.be = b_exp;
        e.f  = (in_cnt == 0);
        e.l  = (in_cnt == klen_m - 1);
        q.push_back(e);
        in_cnt++;
        last_hs = cyc;
      end
      prev_fire = a_ready;
      if (done) begin
        done_n++;
        done_cyc   = cyc;
        ab_at_done = aborted;
        chk("done_xpv", xp_valid, 0);
        chk("done_rdy", a_ready, 0);
      end
    end
  end

  task automatic tile(input int k, input int lead, input int stall_beat,
                      input int stall_len, input int abort_at,
                      input bit mid_start, input int rst_at,
                      input bit exp_ab, input int exp_beats);
    int  stall_c = 0;
    bit  ab_done = 1'b0;
    bit  ms_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (c > 0 && done_n > 0) break;
      a_mant    = MVW'(rnd512());
      b_mant    = MVW'(rnd512());
      a_exp     = EVW'(rnd512());
      b_exp     = EVW'(rnd512());
      cfg_start = (c == 0);
      cfg_k_len = KW'(k);
      cfg_abort = 1'b0;
      if (c > 0 && mid_start && !ms_done && in_cnt == 1) begin
        cfg_start = 1'b1;
        cfg_k_len = KW'(2);
        ms_done   = 1'b1;
      end
      a_valid  = (c >= 1) && (in_cnt < k);
      b_valid  = a_valid && (c >= 1 + lead);
      xp_ready = 1'b1;
      if (out_cnt == stall_beat && stall_c < stall_len) begin
        xp_ready = 1'b0;
        stall_c++;
      end
      if (abort_at >= 0 && !ab_done && in_cnt == abort_at) begin
        cfg_abort = 1'b1;
        ab_done   = 1'b1;
      end
      if (rst_at >= 0 && in_cnt == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cfg_start = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        @(negedge clk);
        chk("rst_xpv", xp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {aborted, xp_first, xp_last}, 3'b000);
        chk("rst_vec", xp_vec1_mant, '0);
        repeat (4) @(negedge clk);
        chk("rst_no_done", done_n, 0);
        return;
      end
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    xp_ready  = 1'b1;
    chk("done_cnt", done_n, 1);
    chk("aborted", ab_at_done, exp_ab);
    chk("beats", out_cnt, exp_beats);
    if (!exp_ab) chk("q_left", q.size(), 0);
    if (!exp_ab && k > 0) chk("done_lat", done_cyc - last_hs, 2);
    if (k == 0) begin
      chk("k0_lat", done_cyc - start_cyc, 1);
      chk("k0_hs", in_cnt, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", {done, aborted}, 2'b00);
    chk("rst_xp0", {xp_valid, xp_first, xp_last}, 3'b000);
    chk("rst_vec0", xp_vec2_exp_raw, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tile(4, 0, -1, 0, -1, 1'b0, -1, 1'b0, 4);
    tile(0, 0, -1, 0, -1, 1'b0, -1, 1'b0, 0);
    tile(3, 0, 1, 5, -1, 1'b0, -1, 1'b0, 3);
    tile(2, 3, -1, 0, -1, 1'b0, -1, 1'b0, 2);
    tile(8, 0, -1, 0, 3, 1'b1, -1, 1'b1, 3);
    tile(4, 0, 2, 2, -1, 1'b0, -1, 1'b0, 4);
    tile(5, 0, -1, 0, -1, 1'b0, 2, 1'b0, 0);
    tile(2, 0, -1, 0, -1, 1'b0, -1, 1'b0, 2);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
